round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
Match/round sequencer for the PVP fight datapath. It sits between the game resolver and the two per-player HP trackers.
- Gates hit events so damage only lands during live fighting.
- Clears both HP trackers at round start and runs the round countdown and timer.
- Decides each round outcome from KO pulses, or from HP comparison on timeout.
- Tallies round wins and declares the match winner.
All sequential state advances only on SCEN (game tick enable).

Parameters:
DMG_WIDTH, 7, HP value width; matches the HP trackers.
ROUNDS_TO_WIN, 2, round wins needed to take the match (1..7).
ROUND_SEC, 99, round length in seconds (1..127).
TICKS_PER_SEC, 60, SCEN ticks per second.
COUNTDOWN_SEC, 3, pre-round countdown in seconds (1..7).
HOLD_TICKS, 120, SCEN ticks spent in the post-round hold.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
SCEN  in  1  game tick enable; all state updates qualified by it
start  in  1  level; starts a match from IDLE or MATCH_OVER
p1_hit_in  in  1  resolver: hit lands on P1 (1-cycle)
p2_hit_in  in  1  resolver: hit lands on P2 (1-cycle)
p1_ko_pulse  in  1  P1 tracker KO pulse
p2_ko_pulse  in  1  P2 tracker KO pulse
p1_hp  in  DMG_WIDTH  P1 current HP
p2_hp  in  DMG_WIDTH  P2 current HP
p1_hit_out  out  1  gated hit event to P1 tracker
p2_hit_out  out  1  gated hit event to P2 tracker
hp_clear  out  1  1-cycle pulse; restores both trackers to max HP
state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_OVER
timer_sec  out  7  seconds remaining (countdown value or round clock)
round_num  out  4  current round number, 1-based
p1_wins  out  3  P1 round wins
p2_wins  out  3  P2 round wins
round_result  out  2  last round: 0 none, 1 P1, 2 P2, 3 draw
winner  out  2  match winner: 0 none, 1 P1, 2 P2

Behaviour:
- Reset values: state=IDLE; timer_sec=0; round_num=0; p1_wins=p2_wins=0; round_result=0; winner=0; hp_clear=0; tick counter=0.
- Nothing below changes on a cycle where SCEN=0, and hp_clear holds its value. Exception: the gated hit outputs are combinational and follow their formula on every cycle.
- Hit gating (combinational, 0-cycle latency):
  - p1_hit_out = p1_hit_in & (state==FIGHT) & ~p1_ko & ~p2_ko, where p1_ko/p2_ko are the KO pulses arriving this cycle. p2_hit_out is symmetric.
  - Hits in any other state are dropped.
- hp_clear: registered, held 1 for exactly one SCEN tick, asserted on the tick the FSM enters COUNTDOWN.
- IDLE or MATCH_OVER, start=1 on a SCEN tick:
  - Clear wins, winner and round_result.
  - Set round_num=1 and timer_sec=COUNTDOWN_SEC; zero the tick counter.
  - Go to COUNTDOWN with hp_clear.
- COUNTDOWN:
  - Tick counter counts 0..TICKS_PER_SEC-1. On wrap, timer_sec decrements.
  - When timer_sec would reach 0: go to FIGHT, set timer_sec=ROUND_SEC, zero the tick counter.
- FIGHT, priority top to bottom:
  - Both KO pulses on the same tick: draw.
  - p2_ko_pulse: P1 wins the round.
  - p1_ko_pulse: P2 wins the round.
  - Timer expiry (timer_sec=1 and tick counter wraps): compare HP. Higher HP wins; equal HP is a draw. timer_sec becomes 0.
  - On any outcome: set round_result, increment the winner's wins (saturating at ROUNDS_TO_WIN), zero the tick counter, go to ROUND_END.
- ROUND_END:
  - Hold HOLD_TICKS ticks.
  - Then, if either player's wins equal ROUNDS_TO_WIN: set winner and go to MATCH_OVER.
  - Otherwise: round_num+1 (saturating at 15), timer_sec=COUNTDOWN_SEC, go to COUNTDOWN with hp_clear.
- A draw awards no win; the round number still advances.
- KO pulses outside FIGHT are ignored.
- Asynchronous reset mid-round returns to IDLE immediately. Trackers are reset externally by the same reset.

Optional Feature:
PAUSE_EN:
- Defined: adds input pause (1 bit). While pause=1 in COUNTDOWN or FIGHT, the tick counter and timer freeze and both hit outputs are forced to 0. KO pulses are still honoured, because a hit already applied may complete its KO. Other states ignore pause.
- Undefined: no pause port; behaviour exactly as above.

Test Plan:
- reset, start=1 with TICKS_PER_SEC=4 and SCEN=1 -> hp_clear high for 1 cycle; timer_sec 3,2,1 each 4 ticks, then FIGHT with timer_sec=99.
- p1_hit_in pulse during COUNTDOWN -> p1_hit_out stays 0; the same pulse in FIGHT -> p1_hit_out=1 in the same cycle.
- FIGHT, p2_ko_pulse -> round_result=1, p1_wins=1, ROUND_END for HOLD_TICKS, then COUNTDOWN with round_num=2 and hp_clear pulse.
- p1_ko_pulse and p2_ko_pulse on the same tick -> round_result=3, wins unchanged, round_num advances.
- Timeout with p1_hp=40, p2_hp=55 -> round_result=2. Timeout with 30/30 -> draw.
- P1 wins two rounds -> winner=1, state=MATCH_OVER. Assert reset mid-FIGHT -> all outputs at reset values.

Source files
------------

// File: rtl/round_controller_if.sv
// Bundles the resolver, HP-tracker and status signals of round_controller.
// Optional macro PAUSE_EN adds the pause input.
interface round_controller_if #(
  parameter int DMG_WIDTH = 7
);
  logic                 SCEN;
  logic                 start;
  logic                 p1_hit_in;
  logic                 p2_hit_in;
  logic                 p1_ko_pulse;
  logic                 p2_ko_pulse;
  logic [DMG_WIDTH-1:0] p1_hp;
  logic [DMG_WIDTH-1:0] p2_hp;
`ifdef PAUSE_EN
  logic                 pause;
`endif
  logic                 p1_hit_out;
  logic                 p2_hit_out;
  logic                 hp_clear;
  logic [2:0]           state;
  logic [6:0]           timer_sec;
  logic [3:0]           round_num;
  logic [2:0]           p1_wins;
  logic [2:0]           p2_wins;
  logic [1:0]           round_result;
  logic [1:0]           winner;

  modport master (
    output SCEN, start, p1_hit_in, p2_hit_in, p1_ko_pulse, p2_ko_pulse, p1_hp, p2_hp,
`ifdef PAUSE_EN
    output pause,
`endif
    input  p1_hit_out, p2_hit_out, hp_clear, state, timer_sec, round_num,
    input  p1_wins, p2_wins, round_result, winner
  );

  modport slave (
    input  SCEN, start, p1_hit_in, p2_hit_in, p1_ko_pulse, p2_ko_pulse, p1_hp, p2_hp,
`ifdef PAUSE_EN
    input  pause,
`endif
    output p1_hit_out, p2_hit_out, hp_clear, state, timer_sec, round_num,
    output p1_wins, p2_wins, round_result, winner
  );
endinterface

// File: rtl/round_controller.sv
// PVP match/round sequencer: hit gating, round countdown/timer, KO/timeout outcome, win tally.
// Optional macro PAUSE_EN: freezes timers and blocks hits while bus.pause is high.
module round_controller #(
  parameter int DMG_WIDTH     = 7,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_SEC     = 99,
  parameter int TICKS_PER_SEC = 60,
  parameter int COUNTDOWN_SEC = 3,
  parameter int HOLD_TICKS    = 120
) (
  input  logic               clk,
  input  logic               reset,
  round_controller_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FIGHT      = 3'd2,
    S_ROUND_END  = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  // One counter serves both the per-second divider and the post-round hold.
  localparam int CNT_MAX = (TICKS_PER_SEC > HOLD_TICKS) ? TICKS_PER_SEC : HOLD_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [6:0]    CD_INIT   = 7'(COUNTDOWN_SEC);
  localparam logic [6:0]    RS_INIT   = 7'(ROUND_SEC);
  localparam logic [2:0]    WINS_MAX  = 3'(ROUNDS_TO_WIN);

  state_t        r_state;
  logic [CW-1:0] r_tick;
  logic [6:0]    r_timer;
  logic [3:0]    r_round;
  logic [2:0]    r_p1_wins;
  logic [2:0]    r_p2_wins;
  logic [1:0]    r_result;
  logic [1:0]    r_winner;
  logic          r_hp_clear;

  logic                 w_pause;
  logic                 w_live;
  logic                 w_wrap;
  logic                 w_expire;
  logic                 w_ko_any;
  logic [1:0]           w_outcome;
  logic [DMG_WIDTH-1:0] w_p1_hp;
  logic [DMG_WIDTH-1:0] w_p2_hp;

`ifdef PAUSE_EN
  assign w_pause = bus.pause & ((r_state == S_COUNTDOWN) | (r_state == S_FIGHT));
`else
  assign w_pause = 1'b0;
`endif

  assign w_p1_hp  = bus.p1_hp;
  assign w_p2_hp  = bus.p2_hp;
  assign w_ko_any = bus.p1_ko_pulse | bus.p2_ko_pulse;
  assign w_live   = (r_state == S_FIGHT) & ~w_pause & ~w_ko_any;
  assign w_wrap   = (r_tick == TICK_LAST);
  assign w_expire = (r_state == S_FIGHT) & ~w_pause & w_wrap & (r_timer == 7'd1);

  assign bus.p1_hit_out = bus.p1_hit_in & w_live;
  assign bus.p2_hit_out = bus.p2_hit_in & w_live;

  // Round outcome code: 0 none, 1 P1, 2 P2, 3 draw. KOs outrank the clock.
  always_comb begin
    w_outcome = 2'd0;
    if (r_state == S_FIGHT) begin
      if (bus.p1_ko_pulse && bus.p2_ko_pulse) w_outcome = 2'd3;
      else if (bus.p2_ko_pulse)               w_outcome = 2'd1;
      else if (bus.p1_ko_pulse)               w_outcome = 2'd2;
      else if (w_expire) begin
        if (w_p1_hp > w_p2_hp)      w_outcome = 2'd1;
        else if (w_p2_hp > w_p1_hp) w_outcome = 2'd2;
        else                        w_outcome = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_timer    <= '0;
      r_round    <= '0;
      r_p1_wins  <= '0;
      r_p2_wins  <= '0;
      r_result   <= '0;
      r_winner   <= '0;
      r_hp_clear <= 1'b0;
    end else if (bus.SCEN) begin
      r_hp_clear <= 1'b0;
      case (r_state)
        S_IDLE, S_MATCH_OVER: begin
          if (bus.start) begin
            r_p1_wins  <= '0;
            r_p2_wins  <= '0;
            r_winner   <= '0;
            r_result   <= '0;
            r_round    <= 4'd1;
            r_timer    <= CD_INIT;
            r_tick     <= '0;
            r_hp_clear <= 1'b1;
            r_state    <= S_COUNTDOWN;
          end
        end
        S_COUNTDOWN: begin
          if (!w_pause) begin
            if (w_wrap) begin
              r_tick <= '0;
              if (r_timer == 7'd1) begin
                r_timer <= RS_INIT;
                r_state <= S_FIGHT;
              end else begin
                r_timer <= r_timer - 7'd1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_FIGHT: begin
          if (w_outcome != 2'd0) begin
            r_result <= w_outcome;
            if (w_outcome == 2'd1 && r_p1_wins != WINS_MAX) r_p1_wins <= r_p1_wins + 3'd1;
            if (w_outcome == 2'd2 && r_p2_wins != WINS_MAX) r_p2_wins <= r_p2_wins + 3'd1;
            if (!w_ko_any) r_timer <= '0;
            r_tick  <= '0;
            r_state <= S_ROUND_END;
          end else if (!w_pause) begin
            if (w_wrap) begin
              r_tick  <= '0;
              r_timer <= r_timer - 7'd1;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_ROUND_END: begin
          if (r_tick == HOLD_LAST) begin
            r_tick <= '0;
            if (r_p1_wins == WINS_MAX) begin
              r_winner <= 2'd1;
              r_state  <= S_MATCH_OVER;
            end else if (r_p2_wins == WINS_MAX) begin
              r_winner <= 2'd2;
              r_state  <= S_MATCH_OVER;
            end else begin
              if (r_round != 4'd15) r_round <= r_round + 4'd1;
              r_timer    <= CD_INIT;
              r_hp_clear <= 1'b1;
              r_state    <= S_COUNTDOWN;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.state        = r_state;
  assign bus.timer_sec    = r_timer;
  assign bus.round_num    = r_round;
  assign bus.p1_wins      = r_p1_wins;
  assign bus.p2_wins      = r_p2_wins;
  assign bus.round_result = r_result;
  assign bus.winner       = r_winner;
  assign bus.hp_clear     = r_hp_clear;
endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: expected values queued at drive time, checked on DUT output.
module tb_round_controller;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;
  exp_t sb[$];

  round_controller_if #(.DMG_WIDTH(7)) bus ();

  round_controller #(
    .DMG_WIDTH(7), .ROUNDS_TO_WIN(2), .ROUND_SEC(99),
    .TICKS_PER_SEC(4), .COUNTDOWN_SEC(3), .HOLD_TICKS(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag, input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%0d", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) else begin
        errors++;
        $error("FAIL %s.%s observed=%0d expected=%0d", tag, e.tag, obs, e.value);
      end
    end
  endtask

  task automatic expect_all(input int st, input int tm, input int rn, input int w1,
                            input int w2, input int res, input int win, input int clr);
    push("state", st);   push("timer", tm);  push("round", rn);   push("p1_wins", w1);
    push("p2_wins", w2); push("result", res); push("winner", win); push("hp_clear", clr);
  endtask

  task automatic compare_all(input string tag);
    $display("step %-14s state=%0d timer=%0d round=%0d wins=%0d/%0d result=%0d winner=%0d clr=%0d",
             tag, bus.state, bus.timer_sec, bus.round_num, bus.p1_wins, bus.p2_wins,
             bus.round_result, bus.winner, bus.hp_clear);
    pop_cmp({tag, ".state"},    32'(bus.state));
    pop_cmp({tag, ".timer"},    32'(bus.timer_sec));
    pop_cmp({tag, ".round"},    32'(bus.round_num));
    pop_cmp({tag, ".p1_wins"},  32'(bus.p1_wins));
    pop_cmp({tag, ".p2_wins"},  32'(bus.p2_wins));
    pop_cmp({tag, ".result"},   32'(bus.round_result));
    pop_cmp({tag, ".winner"},   32'(bus.winner));
    pop_cmp({tag, ".hp_clear"}, 32'(bus.hp_clear));
  endtask

  initial begin
    reset           = 1'b1;
    bus.SCEN        = 1'b0;
    bus.start       = 1'b0;
    bus.p1_hit_in   = 1'b0;
    bus.p2_hit_in   = 1'b0;
    bus.p1_ko_pulse = 1'b0;
    bus.p2_ko_pulse = 1'b0;
    bus.p1_hp       = 7'd100;
    bus.p2_hp       = 7'd100;
`ifdef PAUSE_EN
    bus.pause       = 1'b0;
`endif
    run(2);
    reset = 1'b0;
    expect_all(0, 0, 0, 0, 0, 0, 0, 0); tick(); compare_all("reset");

    // Round 1: start, SCEN gating, countdown 3/2/1 at 4 ticks per second.
    bus.SCEN = 1'b1; bus.start = 1'b1;
    expect_all(1, 3, 1, 0, 0, 0, 0, 1); tick(); compare_all("start");
    bus.start = 1'b0; bus.SCEN = 1'b0;
    expect_all(1, 3, 1, 0, 0, 0, 0, 1); run(3); compare_all("scen_hold");
    bus.SCEN = 1'b1;
    bus.p1_hit_in = 1'b1; push("p1_hit_out", 0); #1; pop_cmp("hit_countdown", 32'(bus.p1_hit_out));
    bus.p1_hit_in = 1'b0;
    expect_all(1, 3, 1, 0, 0, 0, 0, 0); tick();  compare_all("clr_drop");
    expect_all(1, 2, 1, 0, 0, 0, 0, 0); run(3);  compare_all("cd_2");
    expect_all(1, 1, 1, 0, 0, 0, 0, 0); run(4);  compare_all("cd_1");
    expect_all(2, 99, 1, 0, 0, 0, 0, 0); run(4); compare_all("fight_r1");

    bus.p1_hit_in = 1'b1;
    push("p1_hit_out", 1); push("p2_hit_out", 0); #1;
    pop_cmp("hit_fight_p1", 32'(bus.p1_hit_out));
    pop_cmp("hit_fight_p2", 32'(bus.p2_hit_out));
    bus.p2_ko_pulse = 1'b1;
    push("p1_hit_out", 0); #1; pop_cmp("hit_with_ko", 32'(bus.p1_hit_out));
    expect_all(3, 99, 1, 1, 0, 1, 0, 0); tick(); compare_all("p2_ko");
    bus.p2_ko_pulse = 1'b0; bus.p1_hit_in = 1'b0;
    expect_all(3, 99, 1, 1, 0, 1, 0, 0); run(5); compare_all("hold_last");
    expect_all(1, 3, 2, 1, 0, 1, 0, 1); tick();  compare_all("r2_countdown");

    // Round 2: double KO is a draw.
    expect_all(2, 99, 2, 1, 0, 1, 0, 0); run(12); compare_all("fight_r2");
    bus.p1_ko_pulse = 1'b1; bus.p2_ko_pulse = 1'b1;
    expect_all(3, 99, 2, 1, 0, 3, 0, 0); tick(); compare_all("double_ko");
    bus.p1_ko_pulse = 1'b0; bus.p2_ko_pulse = 1'b0;
    expect_all(1, 3, 3, 1, 0, 3, 0, 1); run(6); compare_all("r3_countdown");

    // Round 3: timeout, P2 ahead on HP.
    bus.p1_hp = 7'd40; bus.p2_hp = 7'd55;
    expect_all(2, 99, 3, 1, 0, 3, 0, 0); run(12);  compare_all("fight_r3");
    expect_all(2, 1, 3, 1, 0, 3, 0, 0);  run(395); compare_all("last_second");
    expect_all(3, 0, 3, 1, 1, 2, 0, 0);  tick();   compare_all("timeout_p2");
    expect_all(1, 3, 4, 1, 1, 2, 0, 1);  run(6);   compare_all("r4_countdown");

    // Round 4: timeout with equal HP.
    bus.p1_hp = 7'd30; bus.p2_hp = 7'd30;
    expect_all(2, 99, 4, 1, 1, 2, 0, 0); run(12);  compare_all("fight_r4");
    expect_all(3, 0, 4, 1, 1, 3, 0, 0);  run(396); compare_all("timeout_draw");
    expect_all(1, 3, 5, 1, 1, 3, 0, 1);  run(6);   compare_all("r5_countdown");

    // Round 5: P1 takes the match; KO outside FIGHT is ignored.
    expect_all(2, 99, 5, 1, 1, 3, 0, 0); run(12); compare_all("fight_r5");
    bus.p2_ko_pulse = 1'b1;
    expect_all(3, 99, 5, 2, 1, 1, 0, 0); tick(); compare_all("p1_round_win");
    bus.p2_ko_pulse = 1'b0;
    expect_all(4, 99, 5, 2, 1, 1, 1, 0); run(6); compare_all("match_over");
    bus.p1_ko_pulse = 1'b1;
    expect_all(4, 99, 5, 2, 1, 1, 1, 0); tick(); compare_all("ko_ignored");
    bus.p1_ko_pulse = 1'b0;

    // Rematch from MATCH_OVER, then asynchronous reset mid-fight.
    bus.start = 1'b1;
    expect_all(1, 3, 1, 0, 0, 0, 0, 1); tick(); compare_all("rematch");
    bus.start = 1'b0;
    expect_all(2, 99, 1, 0, 0, 0, 0, 0); run(14); compare_all("fight_rematch");
    bus.p2_hit_in = 1'b1;
    reset = 1'b1;
    expect_all(0, 0, 0, 0, 0, 0, 0, 0); push("p2_hit_out", 0); #1;
    compare_all("async_reset");
    pop_cmp("hit_in_reset", 32'(bus.p2_hit_out));
    bus.p2_hit_in = 1'b0;
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
